div_sched: RTL
==============

# div_sched

Round-robin scheduler that time-shares one `div32` iterative divider among `NREQ` requesters, such as the per-axis PID and mixer normalisation paths. It owns the divider's `start` and `en` and holds its operands stable for the whole operation. It returns quotient and remainder to the requester that issued the operation. Divide-by-zero is short-circuited without touching the divider, and a watchdog aborts a divider that never reports done.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, from 2 to 8.
- `TIMEOUT`, default 64: cycles allowed in WAIT before abort.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global clock enable. While 0, all state freezes, `div_en`=0 and all `req_ready`=0.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: one-hot accept strobe.
- `req_dividend` in NREQ×32: packed `[NREQ-1:0][31:0]`.
- `req_divisor` in NREQ×32: packed `[NREQ-1:0][31:0]`.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out $clog2(NREQ): requester index for the response.
- `rsp_quotient` out 32: quotient returned to the requester.
- `rsp_remainder` out 32: remainder returned to the requester.
- `rsp_dbz` out 1: divisor magnitude was zero.
- `rsp_err` out 1: watchdog timeout.
- `busy` out 1: state is not IDLE.
- `div_en` out 1: divider clock enable.
- `div_start` out 1: divider start.
- `div_dividend` out 32: divider operand.
- `div_divisor` out 32: divider operand.
- `div_quotient` in 32: divider result.
- `div_remainder` in 32: divider result.
- `div_done` in 1: divider done.

## Operation
- Operands pass through unchanged: bit 31 is the sign and `[30:0]` is the magnitude, matching the divider's format.
- States are IDLE, ISSUE, WAIT, SETTLE, RESP and DBZ.
- **IDLE:** if any `req_valid` is set, grant the first valid index strictly after `last_grant`, wrapping modulo NREQ.
  - Assert `req_ready[g]` combinationally this cycle.
  - Latch the operands and g, and set `last_grant`=g.
  - If `req_divisor[g][30:0]`==0, go to DBZ; otherwise go to ISSUE.
- **ISSUE:** `div_start`=1 for exactly one cycle. Load the watchdog counter with 0, then go to WAIT.
- **WAIT:** `div_start`=0.
  - If `div_done`, go to SETTLE.
  - Otherwise, if the counter equals TIMEOUT-1, go to RESP with `err`=1.
  - Otherwise, increment the counter.
- **SETTLE:** one cycle, needed because the divider registers its results on the DONE edge. Capture `div_quotient` and `div_remainder`, then go to RESP.
- **DBZ:** capture quotient = {dividend[31]^divisor[31], 31'h7FFF_FFFF} and remainder = 0, set `dbz`=1, then go to RESP.
- **RESP:** `rsp_valid`=1 for one cycle with the captured `rsp_*` values and `rsp_id`=g, then go to IDLE.
  - On error the response is quotient 0, remainder 0, `rsp_err`=1.
- `div_dividend` and `div_divisor` are driven from the latched operands and held stable from ISSUE through SETTLE.
- `div_en` = `en`.
- Requesters must hold `req_valid` and their operands until `req_ready`. Requests arriving while busy wait; none are dropped.
- There is no response backpressure: the requester must sample `rsp_valid` in the cycle it is high.

## Timing
- Reset values:
  - state IDLE and `last_grant`=NREQ-1, so index 0 wins first.
  - All `req_ready`, `rsp_*`, `busy` and `div_start` outputs are 0.
  - `div_dividend` and `div_divisor` are 0.
- Latency, accept cycle t with `en` held 1:
  - ISSUE at t+1.
  - WAIT from t+2.
  - If `div_done` is seen at cycle d: SETTLE at d+1, `rsp_valid` at d+2.
  - With `div32` this gives `rsp_valid` at t+37.
  - DBZ path: `rsp_valid` at t+2.
- The earliest next accept is the cycle after RESP.
- Timeout: `rsp_valid` with `rsp_err`=1 at t+2+TIMEOUT when `div_done` never rises.
- `div_done` outside WAIT is ignored.
- `rst` mid-operation returns the block to IDLE immediately and discards the pending response. The top level must reset `div32` from the same reset.
- `en`=0 in any state stalls that state and the watchdog counter. Outputs hold, except that `req_ready`, `div_start` and `rsp_valid` are gated to 0.
- A single `req_valid` is granted regardless of the `last_grant` pointer.

## Structure
- Package `div_sched_pkg`: `sched_state_t` enum, `DBZ_MAG` constant (31'h7FFF_FFFF), `DIV_SETTLE` constant (1).
- Sub-module `rr_arbiter`: parameter NREQ; inputs `req` and `last`; outputs `grant_onehot`, `grant_idx` and `any`. It is purely combinational; the `last_grant` register stays in `div_sched`.
- The top level instantiates `div_sched` and `div32` side by side.

## Test plan
- **Single request:** req 0 with 100 / 7 → one `rsp_valid` with id 0, quotient 14, remainder 2, `dbz`=0, `err`=0. `div_start` is high exactly one cycle.
- **Round-robin:** reqs 0, 1 and 3 all held valid → grants in order 0, 1, 3, 0, each only after the previous RESP. `req_ready` is always one-hot.
- **Divide-by-zero:** req 2 with 0x8000_0005 / 0x0000_0000 → `rsp_valid` at t+2, quotient 0xFFFF_FFFF, remainder 0, `dbz`=1, `div_start` never asserted.
- **Timeout:** stub divider that never asserts done, TIMEOUT=8 → `rsp_err`=1 at t+10, then the next request is accepted normally.
- **Reset mid-WAIT:** assert `rst` 10 cycles after accept → state IDLE, no `rsp_valid`. After release, the next grant goes to index 0.
- **Stall:** drop `en` for 5 cycles in WAIT → `rsp_valid` is delayed by exactly 5 cycles and the result is unchanged.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
// Operands use sign-magnitude: bit 31 sign, [30:0] magnitude.
package div_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_RESP   = 3'd4,
      S_DBZ    = 3'd5
   } sched_state_t;

   localparam logic [30:0] DBZ_MAG    = 31'h7FFF_FFFF;
   localparam int          DIV_SETTLE = 1;

   function automatic logic [31:0] dbz_quot(
      input logic [31:0] dvd,
      input logic [31:0] dvs
   );
      return {dvd[31] ^ dvs[31], DBZ_MAG};
   endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly
// after the last grant, wrapping; the pointer lives in the caller.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IW-1:0]   grant_idx,
   output logic            any
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      idx          = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last) + i) % NREQ);
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_idx         = idx;
            grant_onehot[idx] = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/div_sched.sv
// Time-shares one iterative divider among NREQ requesters with
// divide-by-zero bypass and a watchdog on the divider's done.
module div_sched
   import div_sched_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 64,
   localparam int IW      = $clog2(NREQ),
   localparam int CW      = $clog2(TIMEOUT) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0][31:0] req_dividend,
   input  logic [NREQ-1:0][31:0] req_divisor,
   output logic                  rsp_valid,
   output logic [IW-1:0]         rsp_id,
   output logic [31:0]           rsp_quotient,
   output logic [31:0]           rsp_remainder,
   output logic                  rsp_dbz,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  div_en,
   output logic                  div_start,
   output logic [31:0]           div_dividend,
   output logic [31:0]           div_divisor,
   input  logic [31:0]           div_quotient,
   input  logic [31:0]           div_remainder,
   input  logic                  div_done
);

   sched_state_t  state_q, state_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] gid_q, gid_d;
   logic [31:0]   dvd_q, dvd_d;
   logic [31:0]   dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   quo_q, quo_d;
   logic [31:0]   rem_q, rem_d;
   logic          dbz_q, dbz_d;
   logic          err_q, err_d;

   logic [NREQ-1:0] gnt_oh;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req          (req_valid),
      .last         (last_q),
      .grant_onehot (gnt_oh),
      .grant_idx    (gnt_idx),
      .any          (gnt_any)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gid_d   = gid_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      err_d   = err_q;
      if (en) begin
         unique case (state_q)
            S_IDLE: begin
               if (gnt_any) begin
                  last_d  = gnt_idx;
                  gid_d   = gnt_idx;
                  dvd_d   = req_dividend[gnt_idx];
                  dvs_d   = req_divisor[gnt_idx];
                  dbz_d   = 1'b0;
                  err_d   = 1'b0;
                  state_d = (req_divisor[gnt_idx][30:0] == '0)
                          ? S_DBZ : S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (div_done) begin
                  state_d = S_SETTLE;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  quo_d   = '0;
                  rem_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            // Divider results are registered on its done edge.
            S_SETTLE: begin
               quo_d   = div_quotient;
               rem_d   = div_remainder;
               state_d = S_RESP;
            end
            S_DBZ: begin
               quo_d   = dbz_quot(dvd_q, dvs_q);
               rem_d   = '0;
               dbz_d   = 1'b1;
               state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= IW'(NREQ - 1);
         gid_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (en && !rst && state_q == S_IDLE)
                    ? gnt_oh : '0;

   assign rsp_valid     = en && (state_q == S_RESP);
   assign rsp_id        = gid_q;
   assign rsp_quotient  = quo_q;
   assign rsp_remainder = rem_q;
   assign rsp_dbz       = dbz_q;
   assign rsp_err       = err_q;
   assign busy          = (state_q != S_IDLE);
   assign div_en        = en;
   assign div_start     = en && (state_q == S_ISSUE);
   assign div_dividend  = dvd_q;
   assign div_divisor   = dvs_q;

endmodule
